one_shot_pulse_gen: RTL and testbench

Generates a single fixed-length active-high pulse on `o_pulse` when `i_go` rises, and aborts the pulse early when `i_stop` is asserted. It is a small control primitive for timed strobes: enables, triggers and gated windows inside a single clock domain. The output is fully registered and is safe to drive other synchronous logic directly.

---
 rtl/one_shot_pulse_gen_pkg.sv | 11 +
 rtl/one_shot_pulse_gen_rise_edge_detect.sv | 24 ++
 rtl/one_shot_pulse_gen.sv | 65 ++++++
 tb/tb_one_shot_pulse_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/one_shot_pulse_gen_pkg.sv
// Shared types and helpers for the one-shot pulse generator.
package one_shot_pulse_gen_pkg;

   typedef enum logic {IDLE, ACTIVE} state_t;

   // Width of a down-counter able to hold the value len.
   function automatic int cnt_width(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/one_shot_pulse_gen_rise_edge_detect.sv
// Registered-history rising-edge detector: o_rise is high for the cycle in
// which i_sig is high but was low at the previous clock edge.
module rise_edge_detect
   import one_shot_pulse_gen_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic go_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         go_d <= 1'b0;
      end else begin
         go_d <= i_sig;
      end
   end

   assign o_rise = i_sig & ~go_d;

endmodule

// File: rtl/one_shot_pulse_gen.sv
// Fixed-length one-shot pulse on a rising edge of i_go, cut short by i_stop.
// The output comes straight from a flop so it can feed synchronous logic directly.
module one_shot_pulse_gen
   import one_shot_pulse_gen_pkg::*;
#(
   parameter int p_PULSE_LENGTH = 5
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_go,
   input  logic i_stop,
   output logic o_pulse
);

   localparam int CW = cnt_width(p_PULSE_LENGTH);

   if (p_PULSE_LENGTH < 1 || p_PULSE_LENGTH > 65535) begin : g_len_check
      $error("one_shot_pulse_gen: p_PULSE_LENGTH must be in 1..65535");
   end

   localparam logic [CW-1:0] LOAD_VAL = CW'(p_PULSE_LENGTH - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            trig;

   rise_edge_detect u_rise (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_go),
      .o_rise  (trig)
   );

   // Counter holds the number of high cycles still to come after this one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         o_pulse <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (trig && !i_stop) begin
                  state   <= ACTIVE;
                  cnt     <= LOAD_VAL;
                  o_pulse <= 1'b1;
               end
            end
            ACTIVE: begin
               if (i_stop || cnt == '0) begin
                  state   <= IDLE;
                  o_pulse <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               o_pulse <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_one_shot_pulse_gen.sv
// Scenario bench for one_shot_pulse_gen: per-cycle expected output is queued
// as each cycle's stimulus is applied and compared after the clock edge.
module tb_one_shot_pulse_gen;

   localparam int LEN = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic go = 1'b0;
   logic stop = 1'b0;
   logic pulse;

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_q[$];

   one_shot_pulse_gen #(.p_PULSE_LENGTH(LEN)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_go    (go),
      .i_stop  (stop),
      .o_pulse (pulse)
   );

   always #5 clk = ~clk;

   // Apply inputs for one cycle, queue the expected post-edge output, advance
   // to 1 ns after the edge.
   task automatic drive(input logic g, input logic s, input logic e);
      go   = g;
      stop = s;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic e;
      rst_n = 1'b0;
      for (int k = 0; k < 500; k++) begin
         drive(k[0], 1'b0, 1'b0);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
      go = 1'b0;
      #2 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL reset_release cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_single();
      logic e;
      for (int k = 0; k < 14; k++) begin
         drive(k == 0, 1'b0, k < LEN);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL single cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_abort();
      logic e;
      // Stop sampled on the fourth edge of the pulse: three high cycles.
      for (int k = 0; k < 14; k++) begin
         drive(k == 0, k == 3, k < 3);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL abort cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
      // Stop on the very next edge after start gives the minimum 1-cycle pulse.
      for (int k = 0; k < 8; k++) begin
         drive(k == 0, k == 1, k < 1);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL abort_min cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_held_go();
      logic e;
      for (int k = 0; k < 32; k++) begin
         drive((k < 20) || (k >= 21 && k < 24), 1'b0,
               (k < LEN) || (k >= 21 && k < 21 + LEN));
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL held_go cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_retrigger();
      logic e;
      for (int k = 0; k < 12; k++) begin
         drive(k == 0 || k == 2, 1'b0, k < LEN);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL retrigger cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
      // Trigger on the edge where the pulse ends naturally is ignored.
      for (int k = 0; k < 12; k++) begin
         drive(k == 0 || k == LEN, 1'b0, k < LEN);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL end_trigger cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_collision();
      logic e;
      // go+stop together in IDLE, then a lone stop in IDLE: never a pulse.
      for (int k = 0; k < 8; k++) begin
         drive(k == 0, k == 0 || k == 4, 1'b0);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL collision cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic e;
      // One low cycle of go after the pulse ends, then a fresh edge.
      for (int k = 0; k < 16; k++) begin
         drive(k == 0 || k == LEN + 1, 1'b0,
               (k < LEN) || (k >= LEN + 1 && k < 2 * LEN + 1));
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   task automatic test_async_reset();
      logic e;
      for (int k = 0; k < 2; k++) begin
         drive(k == 0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL async_pre cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      exp_q.push_back(1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (pulse !== e) begin
         n_fail++;
         $display("FAIL async_drop got=%b exp=%b", pulse, e);
      end
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         n_tests++;
         if (pulse !== e) begin
            n_fail++;
            $display("FAIL async_post cyc=%0d got=%b exp=%b", k, pulse, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_abort();
      test_held_go();
      test_retrigger();
      test_collision();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
